// File: rtl/prod_disp_pkg.sv
// Shared types and constants for the product BCD display: FSM states,
// display digit codes and active-low 7-segment cathode patterns.
package prod_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ABS,
    CONV,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    DIG_0,
    DIG_1,
    DIG_2,
    DIG_3,
    DIG_4,
    DIG_5,
    DIG_6,
    DIG_7,
    DIG_8,
    DIG_9,
    DIG_DASH,
    DIG_E,
    DIG_BLANK
  } digit_code_t;

  localparam int MAG_W       = 16;
  localparam int BCD_DIGITS  = 5;
  localparam int DISP_DIGITS = 4;

  // Cathode patterns: bit 7 is the decimal point (kept off), [6:0] = g..a.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational digit-code to active-low 7-segment cathode decoder.
module bcd_seg7_decode
  import prod_disp_pkg::*;
(
  input  digit_code_t code,
  output logic [7:0]  cathode
);

  always_comb begin
    cathode = SEG_BLANK;
    case (code)
      DIG_0:    cathode = SEG_0;
      DIG_1:    cathode = SEG_1;
      DIG_2:    cathode = SEG_2;
      DIG_3:    cathode = SEG_3;
      DIG_4:    cathode = SEG_4;
      DIG_5:    cathode = SEG_5;
      DIG_6:    cathode = SEG_6;
      DIG_7:    cathode = SEG_7;
      DIG_8:    cathode = SEG_8;
      DIG_9:    cathode = SEG_9;
      DIG_DASH: cathode = SEG_DASH;
      DIG_E:    cathode = SEG_E;
      default:  cathode = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/prod_bcd_display.sv
// Signed product -> BCD (sequential double-dabble) -> 4-digit multiplexed display.
// Optional macro BLANK_LEADING_ZEROS_EN blanks leading zero digits.
module prod_bcd_display
  import prod_disp_pkg::*;
#(
  parameter int REFRESH_W = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAG_W-1:0]     product,
  output logic [15:0]          bcd,
  output logic                 neg,
  output logic                 ovf,
  output logic                 bcd_valid,
  output logic [3:0]           anode,
  output logic [7:0]           cathode
);

  localparam int SHIFT_W = 4 * BCD_DIGITS;

  state_t                 state_reg, state_next;
  logic [MAG_W-1:0]       prod_reg;
  logic [MAG_W-1:0]       mag_reg;
  logic [SHIFT_W-1:0]     shift_reg;
  logic [3:0]             bit_cnt_reg;
  logic                   neg_work_reg;
  logic [15:0]            bcd_reg;
  logic                   neg_reg;
  logic                   ovf_reg;
  digit_code_t            disp_reg  [DISP_DIGITS];
  digit_code_t            disp_next [DISP_DIGITS];
  logic [REFRESH_W-1:0]   refresh_cnt_reg;

  logic [SHIFT_W-1:0]     adj;
  logic [SHIFT_W-1:0]     shift_next;
  logic                   dd_carry;
  logic                   ovf_next;
  logic [15:0]            res;
  logic [1:0]             digit_sel;

  genvar gi;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    bcd_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ABS;
      end
      ABS:  state_next = CONV;
      CONV: if (bit_cnt_reg == 4'd15) state_next = DONE;
      DONE: begin
        bcd_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- double-dabble step ----------------
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = dd_adjust(shift_reg[gi*4 +: 4]);
    end
  endgenerate

  assign shift_next = {adj[SHIFT_W-2:0], mag_reg[MAG_W-1]};
  // A carry out of the top digit could only mean an undisplayable value.
  assign dd_carry   = adj[SHIFT_W-1];
  assign res        = shift_next[15:0];
  assign ovf_next   = dd_carry | (neg_work_reg ? (shift_next[19:12] != 8'd0)
                                               : (shift_next[19:16] != 4'd0));

  // ---------------- display composition ----------------
`ifdef BLANK_LEADING_ZEROS_EN
  logic [4:1] lead_zero;
  logic [3:0] blank;

  assign lead_zero[4] = 1'b1;
  assign blank[0]     = 1'b0;
  assign disp_next[0] = ovf_next ? DIG_E : digit_code_t'(res[3:0]);

  generate
    for (gi = 1; gi < DISP_DIGITS; gi++) begin : g_disp
      assign lead_zero[gi] = (res[gi*4 +: 4] == 4'd0) && lead_zero[gi+1];
      assign blank[gi]     = lead_zero[gi];
      // The sign lands on the first blanked position left of the leading digit.
      assign disp_next[gi] = ovf_next                                 ? DIG_E    :
                             (neg_work_reg && blank[gi] && !blank[gi-1]) ? DIG_DASH :
                             blank[gi]                                ? DIG_BLANK :
                                                                        digit_code_t'(res[gi*4 +: 4]);
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < DISP_DIGITS; gi++) begin : g_disp
      if (gi == DISP_DIGITS - 1) begin : g_top
        assign disp_next[gi] = ovf_next     ? DIG_E    :
                               neg_work_reg ? DIG_DASH :
                                              digit_code_t'(res[gi*4 +: 4]);
      end else begin : g_low
        assign disp_next[gi] = ovf_next ? DIG_E : digit_code_t'(res[gi*4 +: 4]);
      end
    end
  endgenerate
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_reg     <= '0;
      mag_reg      <= '0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      neg_work_reg <= 1'b0;
      bcd_reg      <= '0;
      neg_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
`ifdef BLANK_LEADING_ZEROS_EN
      disp_reg     <= '{DIG_0, DIG_BLANK, DIG_BLANK, DIG_BLANK};
`else
      disp_reg     <= '{DIG_0, DIG_0, DIG_0, DIG_0};
`endif
    end else begin
      case (state_reg)
        IDLE: if (in_valid) prod_reg <= product;
        ABS: begin
          neg_work_reg <= prod_reg[MAG_W-1];
          mag_reg      <= prod_reg[MAG_W-1] ? (16'd0 - prod_reg) : prod_reg;
          shift_reg    <= '0;
          bit_cnt_reg  <= '0;
        end
        CONV: begin
          shift_reg   <= shift_next;
          mag_reg     <= {mag_reg[MAG_W-2:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd15) begin
            bcd_reg  <= res;
            neg_reg  <= neg_work_reg;
            ovf_reg  <= ovf_next;
            disp_reg <= disp_next;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- refresh scan ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) refresh_cnt_reg <= '0;
    else      refresh_cnt_reg <= refresh_cnt_reg + {{(REFRESH_W-1){1'b0}}, 1'b1};
  end

  assign digit_sel = refresh_cnt_reg[REFRESH_W-1 -: 2];
  assign anode     = ~(4'b0001 << digit_sel);

  bcd_seg7_decode u_decode (
    .code    (disp_reg[digit_sel]),
    .cathode (cathode)
  );

  assign bcd = bcd_reg;
  assign neg = neg_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_prod_bcd_display.sv
// Scoreboard bench for prod_bcd_display: driver pushes expectations, monitor checks
// each bcd_valid pulse and the following full display scan.
module tb_prod_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] product = 16'd0;
  logic [15:0] bcd;
  logic        neg;
  logic        ovf;
  logic        bcd_valid;
  logic [3:0]  anode;
  logic [7:0]  cathode;

`ifdef BLANK_LEADING_ZEROS_EN
  localparam bit BLANK_MODE = 1'b1;
`else
  localparam bit BLANK_MODE = 1'b0;
`endif

  typedef struct {
    logic [15:0]     prod;
    logic [15:0]     bcd;
    logic            neg;
    logic            ovf;
    logic [3:0][7:0] seg;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_seen = 0;
  bit   mon_busy = 1'b0;

  prod_bcd_display #(.REFRESH_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .bcd       (bcd),
    .neg       (neg),
    .ovf       (ovf),
    .bcd_valid (bcd_valid),
    .anode     (anode),
    .cathode   (cathode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] p, input logic [15:0] eb, input logic en,
                      input logic eo, input logic [31:0] seg_off, input logic [31:0] seg_on,
                      input bit keep, output int acc);
    exp_t e;
    int   guard;
    @(negedge clk);
    in_valid = 1'b1;
    product  = p;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    acc   = cyc + 1;
    e.prod = p;
    e.bcd  = eb;
    e.neg  = en;
    e.ovf  = eo;
    e.seg  = BLANK_MODE ? seg_on : seg_off;
    e.cyc  = acc + 17;
    sb.push_back(e);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while ((sb.size() != 0 || mon_busy) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk(name, {31'd0, (sb.size() == 0 && !mon_busy)}, 32'd1);
  endtask

  // Monitor: check result on each pulse, then collect one full 16-cycle scan.
  initial begin
    exp_t            e;
    logic [3:0][7:0] got_seg;
    int              idx;
    forever begin
      @(negedge clk);
      if (rst && bcd_valid) begin
        valid_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          mon_busy = 1'b1;
          $display("txn product=%04h bcd=%04h neg=%0b ovf=%0b cyc=%0d", e.prod, bcd, neg, ovf, cyc);
          chk("latency", cyc, e.cyc);
          chk("bcd", {16'd0, bcd}, {16'd0, e.bcd});
          chk("neg", {31'd0, neg}, {31'd0, e.neg});
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          got_seg = '1;
          for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            case (anode)
              4'b1110: idx = 0;
              4'b1101: idx = 1;
              4'b1011: idx = 2;
              4'b0111: idx = 3;
              default: idx = -1;
            endcase
            if (idx < 0) chk("anode_onehot", {28'd0, anode}, 32'hE);
            else got_seg[idx] = cathode;
          end
          for (int d = 0; d < 4; d++) begin
            chk($sformatf("digit%0d", d), {24'd0, got_seg[d]}, {24'd0, e.seg[d]});
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    int acc_a, acc_b, acc_c, seen_before;
    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_anode", {28'd0, anode}, 32'hE);
    chk("rst_cathode", {24'd0, cathode}, 32'hC0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
    chk("rst_bcd", {16'd0, bcd}, 32'd0);
    chk("rst_neg_ovf", {30'd0, neg, ovf}, 32'd0);
    rst = 1'b1;

    // product, bcd, neg, ovf, segments {d3,d2,d1,d0} without / with blanking
    send(16'h04D2, 16'h1234, 1'b0, 1'b0, 32'hF9A4B099, 32'hF9A4B099, 1'b0, acc_a);
    send(16'hFFC8, 16'h0056, 1'b1, 1'b0, 32'hBFC09282, 32'hFFBF9282, 1'b0, acc_a);
    send(16'h2710, 16'h0000, 1'b0, 1'b1, 32'h86868686, 32'h86868686, 1'b0, acc_a);
    send(16'hFC18, 16'h1000, 1'b1, 1'b1, 32'h86868686, 32'h86868686, 1'b0, acc_a);
    send(16'h8000, 16'h2768, 1'b1, 1'b1, 32'h86868686, 32'h86868686, 1'b0, acc_a);
    send(16'h0007, 16'h0007, 1'b0, 1'b0, 32'hC0C0C0F8, 32'hFFFFFFF8, 1'b0, acc_a);
    send(16'h270F, 16'h9999, 1'b0, 1'b0, 32'h90909090, 32'h90909090, 1'b0, acc_a);
    send(16'hFC19, 16'h0999, 1'b1, 1'b0, 32'hBF909090, 32'hBF909090, 1'b0, acc_a);
    send(16'h03E8, 16'h1000, 1'b0, 1'b0, 32'hF9C0C0C0, 32'hF9C0C0C0, 1'b0, acc_a);
    send(16'h0000, 16'h0000, 1'b0, 1'b0, 32'hC0C0C0C0, 32'hFFFFFFC0, 1'b0, acc_a);
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 32'hBFC0C0F9, 32'hFFFFBFF9, 1'b0, acc_a);
    send(16'h7FFF, 16'h2767, 1'b0, 1'b1, 32'h86868686, 32'h86868686, 1'b0, acc_a);
    send(16'h0064, 16'h0100, 1'b0, 1'b0, 32'hC0F9C0C0, 32'hFFF9C0C0, 1'b0, acc_a);
    wait_idle("drain1");

    // in_valid held with a new value while busy: next accept only after DONE
    send(16'h0205, 16'h0517, 1'b0, 1'b0, 32'hC092F9F8, 32'hFF92F9F8, 1'b1, acc_a);
    send(16'h0042, 16'h0066, 1'b0, 1'b0, 32'hC0C08282, 32'hFFFF8282, 1'b0, acc_b);
    chk("held_accept_gap", acc_b - acc_a, 32'd19);
    wait_idle("drain2");

    // Reset during CONV aborts without a result
    send(16'h04D2, 16'h1234, 1'b0, 1'b0, 32'hF9A4B099, 32'hF9A4B099, 1'b0, acc_c);
    void'(sb.pop_back());
    seen_before = valid_seen;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_bcd_valid", {31'd0, bcd_valid}, 32'd0);
    chk("abort_anode", {28'd0, anode}, 32'hE);
    chk("abort_cathode", {24'd0, cathode}, 32'hC0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_valid", valid_seen - seen_before, 32'd0);

    // Normal operation resumes after the abort
    send(16'hFFC8, 16'h0056, 1'b1, 1'b0, 32'hBFC09282, 32'hFFBF9282, 1'b0, acc_a);
    wait_idle("drain3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
